frame_pattern_gen_ng: RTL
=========================

# frame_pattern_gen_ng

Next-generation test-pattern source for the frame generator datapath. It consumes the same line/frame timing strobes (`dval`, `lval_negedge`, `fval_posedge`) and produces one registered pixel per valid cycle. Pixel width, frame geometry and checker tile size are parametrised. The pattern select is frame-synchronous, and the block adds vertical gradient, colour-bar, grid and animated moving-box patterns plus status outputs.

## Interface

Parameters:
- `PIX_W`, default 8: pixel width in bits. `MAXV` = 2^PIX_W − 1.
- `DVAL_HIGH`, default 640: active pixels per line. Must be ≥ 8.
- `ROW_COUNT`, default 480: active lines per frame. Must be ≥ 8.
- `TILE_LOG2`, default 4: checker and grid tile edge is 2^TILE_LOG2 pixels.
- `BOX_SIZE`, default 32: moving-box edge in pixels. Must be less than both `DVAL_HIGH` and `ROW_COUNT`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `sel`  in  3  requested pattern.
- `dval`  in  1  pixel valid.
- `lval_negedge`  in  1  single-cycle end-of-line strobe.
- `fval_posedge`  in  1  single-cycle start-of-frame strobe.
- `pix_value`  out  PIX_W  pixel.
- `pix_valid`  out  1  `dval` delayed by one cycle.
- `frame_cnt`  out  16  count of `fval_posedge` events since reset; wraps.
- `line_overrun`  out  1  sticky: more than `DVAL_HIGH` valid cycles occurred in one line.

## Operation

- Position counters:
  - x: pixel index within the line, 0-based. Increments on each `dval`; saturates at `DVAL_HIGH`−1.
  - y: line index. Increments on `lval_negedge`; saturates at `ROW_COUNT`−1.
  - `fval_posedge` clears x and y. `lval_negedge` clears x.
- `line_overrun` sets when `dval` is asserted while x = `DVAL_HIGH`−1 and x has already been used for that index. It clears on `fval_posedge`.
- `act_sel` (internal) loads `sel` on `fval_posedge` only. Changing `sel` mid-frame has no effect until the next frame.
- Patterns, selected by `act_sel` value:
  - 0: black, output 0.
  - 1: white, output `MAXV`.
  - 2: horizontal gradient, floor(x·2^PIX_W / `DVAL_HIGH`). Computed by a quotient/remainder accumulator: each `dval` adds the constant quotient and remainder of 2^PIX_W ÷ `DVAL_HIGH`, then applies one conditional subtract-and-carry. No divider.
  - 3: checker, `MAXV` when x[TILE_LOG2] XOR y[TILE_LOG2] is 1, otherwise 0. Top-left tile is black.
  - 4: vertical gradient, floor(y·2^PIX_W / `ROW_COUNT`). Same accumulator scheme, stepped on `lval_negedge`.
  - 5: colour bars, 8 bars. Bar index b = largest k with x ≥ k·`DVAL_HIGH`/8 (integer division). Level = `MAXV` − floor(b·`MAXV`/7), taken from a localparam table.
  - 6: moving box (see Configuration).
  - 7: grid, `MAXV` when x or y is a multiple of 2^TILE_LOG2, otherwise 0.
- Moving box: position (bx, by), directions (dx, dy), all reset to (0, 0, +, +).
  - Updates on each `fval_posedge`. Each axis steps 1 pixel in its current direction.
  - At 0 or at max (`DVAL_HIGH`−`BOX_SIZE`, or `ROW_COUNT`−`BOX_SIZE`), the direction reverses and the position steps away from the limit in the same cycle.
  - Pixel is `MAXV` inside [bx, bx+`BOX_SIZE`) × [by, by+`BOX_SIZE`), otherwise 0.
- Pixels beyond `DVAL_HIGH` in a line reuse x = `DVAL_HIGH`−1.

## Timing

- Reset values: `pix_value`, `pix_valid`, `frame_cnt`, `line_overrun` are all 0. x, y, accumulators and `act_sel` are 0. Box is at (0, 0) moving +,+. Reset mid-line takes effect immediately.
- Latency is 1 cycle: `dval` at cycle t gives `pix_valid` = 1 and `pix_value` for the current x at t+1. When `pix_valid` = 0, `pix_value` = 0.
- Simultaneous `fval_posedge` and `lval_negedge`: `fval_posedge` wins, so x and y are 0.
- `fval_posedge` together with `dval` in the same cycle: that pixel uses x = 0, y = 0 and the newly loaded `act_sel`.
- `frame_cnt` and the box position update in the `fval_posedge` cycle. The first pixel of the new frame uses the new position.

## Configuration

- `FRAME_PATTERN_GEN_MOVING_BOX_EN` defined: pattern 6 is the moving box; box registers and bounce logic are compiled in.
- Not defined: the box logic is absent, and pattern 6 outputs constant `MAXV`>>1 (mid-grey, 127 at `PIX_W`=8).

## Test plan

All scenarios use the default parameters.
- Horizontal gradient (`sel`=2, frame start, 640 `dval` cycles) → x=0 gives 0, x=320 gives 128, x=639 gives 255, monotonic non-decreasing.
- Checker (`sel`=3) → line 0: x=15 gives 0, x=16 gives 255. Line 16: x=0 gives 255. Also check line advance through `lval_negedge`.
- Frame-sync select: `sel` changes 0→1 mid-frame → `pix_value` stays 0 until the next `fval_posedge`, then is 255. `frame_cnt` increments by 1.
- Overrun: 642 `dval` cycles in one line with `sel`=2 → `line_overrun`=1 after the 641st pixel. Pixels 641–642 read 255. Next `fval_posedge` clears the flag.
- Colour bars (`sel`=5) → x=0 gives 255, x=80 gives 219, x=639 gives 0. Simultaneous `fval_posedge` + `lval_negedge` gives y=0.
- Moving box (`sel`=6, macro on) → after frames 0/1/2 the box is at (0,0)/(1,1)/(2,2). Pixel (1,1) in frame 1 is 255 and (0,0) is 0. X direction reverses at bx=608. With the macro off, every pixel reads 127. Asserting `rst` mid-frame zeroes all outputs immediately.

Source files
------------

// File: rtl/frame_pattern_gen_ng_if.sv
// Pixel-source bus between the frame timing logic and frame_pattern_gen_ng.
// Carries the timing strobes and pattern select into the generator, and the
// pixel stream and status flags back out of it.
// i_* fields are driven by the master (timing side); o_* fields are driven by the generator (slave).
interface frame_pattern_gen_ng_if #(
   parameter int PIX_W = 8
);
   logic [2:0]       i_sel;
   logic             i_dval;
   logic             i_lval_negedge;
   logic             i_fval_posedge;
   logic [PIX_W-1:0] o_pix_value;
   logic             o_pix_valid;
   logic [15:0]      o_frame_cnt;
   logic             o_line_overrun;

   modport master (
      output i_sel, i_dval, i_lval_negedge, i_fval_posedge,
      input  o_pix_value, o_pix_valid, o_frame_cnt, o_line_overrun
   );

   modport slave (
      input  i_sel, i_dval, i_lval_negedge, i_fval_posedge,
      output o_pix_value, o_pix_valid, o_frame_cnt, o_line_overrun
   );
endinterface

// File: rtl/frame_pattern_gen_ng.sv
// Test-pattern source: one registered pixel per dval cycle, pattern chosen per frame.
// Latency 1 cycle (dval -> pix_valid/pix_value); no backpressure, the pixel stream is free-running.
// Optional feature macro: FRAME_PATTERN_GEN_MOVING_BOX_EN (pattern 6 = bouncing box, else mid-grey).
// Ports: clk, rst (async, active-high); pg (slave modport): i_sel, i_dval, i_lval_negedge,
//        i_fval_posedge in; o_pix_value, o_pix_valid, o_frame_cnt, o_line_overrun out.
// Assumes 1 <= TILE_LOG2 < clog2 of both DVAL_HIGH and ROW_COUNT.
module frame_pattern_gen_ng #(
   parameter int PIX_W     = 8,
   parameter int DVAL_HIGH = 640,
   parameter int ROW_COUNT = 480,
   parameter int TILE_LOG2 = 4,
   parameter int BOX_SIZE  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   frame_pattern_gen_ng_if.slave pg
);
   localparam int XW  = $clog2(DVAL_HIGH);
   localparam int YW  = $clog2(ROW_COUNT);
   localparam int HRW = XW + 1;
   localparam int VRW = YW + 1;
   localparam int MAXI = (1 << PIX_W) - 1;
   localparam logic [PIX_W-1:0] MAXV = PIX_W'(MAXI);
   localparam longint FULL = longint'(1) << PIX_W;

   // Gradient steps: 2^PIX_W / N split into quotient and remainder so the
   // running value floor(i * 2^PIX_W / N) needs only adds and one compare.
   localparam logic [PIX_W-1:0] HQ = PIX_W'(FULL / DVAL_HIGH);
   localparam logic [HRW-1:0]   HR = HRW'(FULL % DVAL_HIGH);
   localparam logic [HRW-1:0]   HD = HRW'(DVAL_HIGH);
   localparam logic [PIX_W-1:0] VQ = PIX_W'(FULL / ROW_COUNT);
   localparam logic [VRW-1:0]   VR = VRW'(FULL % ROW_COUNT);
   localparam logic [VRW-1:0]   VD = VRW'(ROW_COUNT);

   localparam logic [XW-1:0] X_MAX = XW'(DVAL_HIGH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROW_COUNT - 1);

   localparam logic [PIX_W-1:0] BAR_LVL [8] = '{
      PIX_W'(MAXI),
      PIX_W'(MAXI - (1 * MAXI) / 7),
      PIX_W'(MAXI - (2 * MAXI) / 7),
      PIX_W'(MAXI - (3 * MAXI) / 7),
      PIX_W'(MAXI - (4 * MAXI) / 7),
      PIX_W'(MAXI - (5 * MAXI) / 7),
      PIX_W'(MAXI - (6 * MAXI) / 7),
      PIX_W'(MAXI - (7 * MAXI) / 7)
   };

   // State
   logic [XW-1:0]    r_x;
   logic [YW-1:0]    r_y;
   logic [PIX_W-1:0] r_hacc;
   logic [HRW-1:0]   r_hrem;
   logic [PIX_W-1:0] r_vacc;
   logic [VRW-1:0]   r_vrem;
   logic             r_x_used;     // last x index already consumed in this line
   logic             r_ovr;
   logic [2:0]       r_sel;
   logic [15:0]      r_frame_cnt;
   logic [PIX_W-1:0] r_pix;
   logic             r_pix_vld;

   // Values seen by the pixel in this cycle: a start-of-frame strobe zeroes the
   // position and loads the new select before the pixel is evaluated.
   logic [XW-1:0]    w_x_cur;
   logic [YW-1:0]    w_y_cur;
   logic [PIX_W-1:0] w_hacc_cur;
   logic [HRW-1:0]   w_hrem_cur;
   logic [PIX_W-1:0] w_vacc_cur;
   logic [VRW-1:0]   w_vrem_cur;
   logic             w_used_cur;
   logic [2:0]       w_sel_cur;

   logic [XW-1:0]    w_x_nxt;
   logic [YW-1:0]    w_y_nxt;
   logic [PIX_W-1:0] w_hacc_nxt;
   logic [HRW-1:0]   w_hrem_nxt;
   logic [PIX_W-1:0] w_vacc_nxt;
   logic [VRW-1:0]   w_vrem_nxt;
   logic             w_used_nxt;
   logic             w_ovr_nxt;
   logic [HRW-1:0]   w_hsum;
   logic [VRW-1:0]   w_vsum;
   logic [2:0]       w_bar;
   logic [PIX_W-1:0] w_box_pix;
   logic [PIX_W-1:0] w_pat;

   wire w_fval = pg.i_fval_posedge;
   wire w_lval = pg.i_lval_negedge & ~pg.i_fval_posedge;  // start-of-frame wins
   wire w_dval = pg.i_dval;

   always_comb begin
      w_x_cur    = w_fval ? '0 : r_x;
      w_y_cur    = w_fval ? '0 : r_y;
      w_hacc_cur = w_fval ? '0 : r_hacc;
      w_hrem_cur = w_fval ? '0 : r_hrem;
      w_vacc_cur = w_fval ? '0 : r_vacc;
      w_vrem_cur = w_fval ? '0 : r_vrem;
      w_used_cur = w_fval ? 1'b0 : r_x_used;
      w_sel_cur  = w_fval ? pg.i_sel : r_sel;

      // Horizontal position and gradient accumulator
      w_hsum     = w_hrem_cur + HR;
      w_x_nxt    = w_x_cur;
      w_hacc_nxt = w_hacc_cur;
      w_hrem_nxt = w_hrem_cur;
      w_used_nxt = w_used_cur;
      if (w_lval) begin
         w_x_nxt    = '0;
         w_hacc_nxt = '0;
         w_hrem_nxt = '0;
         w_used_nxt = 1'b0;
      end else if (w_dval && (w_x_cur != X_MAX)) begin
         w_x_nxt = w_x_cur + XW'(1);
         if (w_hsum >= HD) begin
            w_hrem_nxt = w_hsum - HD;
            w_hacc_nxt = w_hacc_cur + HQ + PIX_W'(1);
         end else begin
            w_hrem_nxt = w_hsum;
            w_hacc_nxt = w_hacc_cur + HQ;
         end
      end else if (w_dval) begin
         w_used_nxt = 1'b1;
      end

      // Vertical position and gradient accumulator
      w_vsum     = w_vrem_cur + VR;
      w_y_nxt    = w_y_cur;
      w_vacc_nxt = w_vacc_cur;
      w_vrem_nxt = w_vrem_cur;
      if (w_lval && (w_y_cur != Y_MAX)) begin
         w_y_nxt = w_y_cur + YW'(1);
         if (w_vsum >= VD) begin
            w_vrem_nxt = w_vsum - VD;
            w_vacc_nxt = w_vacc_cur + VQ + PIX_W'(1);
         end else begin
            w_vrem_nxt = w_vsum;
            w_vacc_nxt = w_vacc_cur + VQ;
         end
      end

      // A second pixel on the last index means the line ran long.
      w_ovr_nxt = w_fval ? 1'b0 : (r_ovr | (w_dval & w_used_cur & (w_x_cur == X_MAX)));

      // Colour bar index: count of bar boundaries at or left of x
      w_bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (int'(w_x_cur) >= (k * DVAL_HIGH) / 8) w_bar = 3'(k);
      end

      case (w_sel_cur)
         3'd0:    w_pat = '0;
         3'd1:    w_pat = MAXV;
         3'd2:    w_pat = w_hacc_cur;
         3'd3:    w_pat = (w_x_cur[TILE_LOG2] ^ w_y_cur[TILE_LOG2]) ? MAXV : '0;
         3'd4:    w_pat = w_vacc_cur;
         3'd5:    w_pat = BAR_LVL[w_bar];
         3'd6:    w_pat = w_box_pix;
         3'd7:    w_pat = ((w_x_cur[TILE_LOG2-1:0] == '0) || (w_y_cur[TILE_LOG2-1:0] == '0)) ? MAXV : '0;
         default: w_pat = '0;
      endcase
   end

`ifdef FRAME_PATTERN_GEN_MOVING_BOX_EN
   localparam logic [XW-1:0] BX_MAX = XW'(DVAL_HIGH - BOX_SIZE);
   localparam logic [YW-1:0] BY_MAX = YW'(ROW_COUNT - BOX_SIZE);

   logic [XW-1:0] r_bx, w_bx_nxt, w_bx_cur;
   logic [YW-1:0] r_by, w_by_nxt, w_by_cur;
   logic          r_bdx, r_bdy, w_bdx_nxt, w_bdy_nxt;   // 1 = moving towards larger coordinate
   logic          w_in_x, w_in_y;

   always_comb begin
      // At a limit the box always heads back inward, whatever its stored direction.
      w_bx_nxt  = r_bx;
      w_bdx_nxt = r_bdx;
      if (r_bx == '0) begin
         w_bx_nxt  = XW'(1);
         w_bdx_nxt = 1'b1;
      end else if (r_bx == BX_MAX) begin
         w_bx_nxt  = BX_MAX - XW'(1);
         w_bdx_nxt = 1'b0;
      end else if (r_bdx) begin
         w_bx_nxt = r_bx + XW'(1);
      end else begin
         w_bx_nxt = r_bx - XW'(1);
      end

      w_by_nxt  = r_by;
      w_bdy_nxt = r_bdy;
      if (r_by == '0) begin
         w_by_nxt  = YW'(1);
         w_bdy_nxt = 1'b1;
      end else if (r_by == BY_MAX) begin
         w_by_nxt  = BY_MAX - YW'(1);
         w_bdy_nxt = 1'b0;
      end else if (r_bdy) begin
         w_by_nxt = r_by + YW'(1);
      end else begin
         w_by_nxt = r_by - YW'(1);
      end

      // The first pixel of a frame already sees the moved box.
      w_bx_cur = w_fval ? w_bx_nxt : r_bx;
      w_by_cur = w_fval ? w_by_nxt : r_by;
      w_in_x   = ({1'b0, w_x_cur} >= {1'b0, w_bx_cur}) &&
                 ({1'b0, w_x_cur} <  ({1'b0, w_bx_cur} + (XW+1)'(BOX_SIZE)));
      w_in_y   = ({1'b0, w_y_cur} >= {1'b0, w_by_cur}) &&
                 ({1'b0, w_y_cur} <  ({1'b0, w_by_cur} + (YW+1)'(BOX_SIZE)));
      w_box_pix = (w_in_x && w_in_y) ? MAXV : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bx  <= '0;
         r_by  <= '0;
         r_bdx <= 1'b1;
         r_bdy <= 1'b1;
      end else if (w_fval) begin
         r_bx  <= w_bx_nxt;
         r_by  <= w_by_nxt;
         r_bdx <= w_bdx_nxt;
         r_bdy <= w_bdy_nxt;
      end
   end
`else
   assign w_box_pix = MAXV >> 1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x         <= '0;
         r_y         <= '0;
         r_hacc      <= '0;
         r_hrem      <= '0;
         r_vacc      <= '0;
         r_vrem      <= '0;
         r_x_used    <= 1'b0;
         r_ovr       <= 1'b0;
         r_sel       <= '0;
         r_frame_cnt <= '0;
         r_pix       <= '0;
         r_pix_vld   <= 1'b0;
      end else begin
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_hacc      <= w_hacc_nxt;
         r_hrem      <= w_hrem_nxt;
         r_vacc      <= w_vacc_nxt;
         r_vrem      <= w_vrem_nxt;
         r_x_used    <= w_used_nxt;
         r_ovr       <= w_ovr_nxt;
         r_sel       <= w_sel_cur;
         r_frame_cnt <= w_fval ? r_frame_cnt + 16'd1 : r_frame_cnt;
         r_pix       <= w_dval ? w_pat : '0;
         r_pix_vld   <= w_dval;
      end
   end

   assign pg.o_pix_value    = r_pix;
   assign pg.o_pix_valid    = r_pix_vld;
   assign pg.o_frame_cnt    = r_frame_cnt;
   assign pg.o_line_overrun = r_ovr;

endmodule
